// File: rtl/pipelined_adder_drain.sv
// Valid/ready wrapper around a globally-enabled WIDTH-stage pipelined adder.
// Tracks stage occupancy and stalls the adder only when a finished result cannot be stored.
module pipelined_adder_drain #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic                     in_cin,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    output logic                     add_cin,
    output logic                     add_en,
    input  logic [WIDTH-1:0]         add_s,
    input  logic                     add_c,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_s,
    output logic                     out_c,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_vld;
    logic [CW-1:0]    r_count;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [WIDTH:0]   r_mem [DEPTH];

    logic w_vld_last;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_accept;
    logic w_en;

    assign w_vld_last = r_vld[WIDTH-1];
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_pop      = out_valid & out_ready;
    // A bubble at the pipeline end may always advance; a real result only when it can be stored.
    assign w_en       = ~w_vld_last | ~w_full | w_pop;
    assign w_accept   = in_valid & w_en;
    assign w_push     = w_vld_last & w_en;

    assign add_a    = in_a;
    assign add_b    = in_b;
    assign add_cin  = in_cin;
    assign add_en   = w_en;
    assign in_ready = w_en;

    assign count     = r_count;
    assign out_valid = (r_count != '0);
    assign out_s     = out_valid ? r_mem[r_rd_ptr][WIDTH-1:0] : '0;
    assign out_c     = out_valid ? r_mem[r_rd_ptr][WIDTH]     : 1'b0;

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld    <= '0;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_en) begin
                r_vld <= (r_vld << 1) | WIDTH'(w_accept);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the FIFO storage has no reset; stale entries are never visible because out_valid gates them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {add_c, add_s};
        end
    end

endmodule

// File: tb/tb_pipelined_adder_drain.sv
// Self-checking bench: behavioural adder pipeline as environment, in-order scoreboard of a+b+cin.
module tb_pipelined_adder_drain;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic             add_en;
    logic [WIDTH-1:0] add_s;
    logic             add_c;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_s;
    logic             out_c;
    logic [CW-1:0]    count;

    int n_checks = 0;
    int n_pass   = 0;
    logic [WIDTH:0] exp_q [$];

    pipelined_adder_drain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_en    (add_en),
        .add_s     (add_s),
        .add_c     (add_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_c     (out_c),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached adder: WIDTH enabled edges from operands to sum, frozen when add_en is low, never reset.
    logic [WIDTH:0] adder_st [WIDTH];
    always @(posedge clk) begin
        if (add_en) begin
            adder_st[0] <= {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
            for (int k = 1; k < WIDTH; k++) adder_st[k] <= adder_st[k-1];
        end
    end
    assign add_s = adder_st[WIDTH-1][WIDTH-1:0];
    assign add_c = adder_st[WIDTH-1][WIDTH];

    function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic cin);
        int s;
        s = int'(a) + int'(b) + int'(cin);
        return (WIDTH+1)'(s);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic drive_rand();
        in_valid = 1'b1;
        in_a     = WIDTH'($urandom);
        in_b     = WIDTH'($urandom);
        in_cin   = 1'($urandom);
    endtask

    // One clock: sample handshakes away from the edge, update the scoreboard, then cross the edge.
    task automatic step(output bit acc);
        logic [WIDTH:0] head;
        #1;
        acc = in_valid && in_ready;
        if (acc) exp_q.push_back(ref_sum(in_a, in_b, in_cin));
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("pop_without_result", 32'd1, 32'd0);
            end else begin
                head = exp_q.pop_front();
                check("pop_data", {out_c, out_s}, head);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit acc;
        int sent;
        int stream_acc;

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_out_s", out_s, 0);
        check("rst_out_c", out_c, 0);
        check("rst_in_ready", in_ready, 1);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single op 3+5 with minimum latency
        in_valid = 1'b1; in_a = 4'h3; in_b = 4'h5; in_cin = 1'b0;
        step(acc);
        check("single_accept", acc, 1);
        in_valid = 1'b0;
        for (int i = 1; i < WIDTH; i++) begin
            step(acc);
            check("single_not_early", out_valid, 0);
        end
        step(acc);
        check("single_valid", out_valid, 1);
        check("single_s", out_s, 4'h8);
        check("single_c", out_c, 0);
        step(acc);
        check("single_deassert", out_valid, 0);

        // Carry out
        in_valid = 1'b1; in_a = 4'hF; in_b = 4'h1; in_cin = 1'b1;
        step(acc);
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) step(acc);
        check("carry_valid", out_valid, 1);
        check("carry_s", out_s, 4'h1);
        check("carry_c", out_c, 1);

        // 16 back-to-back random ops at full throughput
        stream_acc = 0;
        for (int i = 0; i < 16 + WIDTH; i++) begin
            if (i < 16) begin
                drive_rand();
                #1;
                check("stream_in_ready", in_ready, 1);
            end else begin
                in_valid = 1'b0;
            end
            step(acc);
            stream_acc += int'(acc);
            if (i >= WIDTH) begin
                check("stream_one_per_cycle", out_valid, 1);
                check("stream_count_low", 32'(count <= CW'(1)), 1);
            end
        end
        check("stream_accepted", stream_acc, 16);
        step(acc);
        check("stream_drained", exp_q.size(), 0);
        check("stream_count_zero", count, 0);

        // Backpressure: only WIDTH+DEPTH ops fit
        out_ready = 1'b0;
        sent = 0;
        drive_rand();
        for (int cyc = 0; cyc < 16; cyc++) begin
            step(acc);
            if (acc) begin
                sent++;
                if (sent < 10) drive_rand(); else in_valid = 1'b0;
            end
        end
        check("bp_accepted", sent, WIDTH + DEPTH);
        check("bp_count_full", count, DEPTH);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_out_valid", out_valid, 1);

        // Full FIFO with simultaneous pop keeps the pipeline moving
        out_ready = 1'b1;
        #1;
        check("full_pop_in_ready", in_ready, 1);
        step(acc);
        check("full_pop_accept", acc, 1);
        check("full_pop_count", count, DEPTH);
        if (acc) begin
            sent++;
            if (sent < 10) drive_rand(); else in_valid = 1'b0;
        end
        for (int cyc = 0; cyc < 40 && sent < 10; cyc++) begin
            step(acc);
            if (acc) begin
                sent++;
                if (sent < 10) drive_rand(); else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("bp_all_sent", sent, 10);
        for (int cyc = 0; cyc < 40 && (exp_q.size() != 0 || out_valid); cyc++) step(acc);
        check("bp_drain_empty", exp_q.size(), 0);
        check("bp_drain_count", count, 0);

        // Bubble collapse: full FIFO, single op behind bubbles still advances to the last stage
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive_rand();
            step(acc);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 12 && count != CW'(DEPTH); i++) step(acc);
        check("bubble_fifo_full", count, DEPTH);
        check("bubble_ready_when_full", in_ready, 1);
        drive_rand();
        step(acc);
        check("bubble_accept", acc, 1);
        in_valid = 1'b0;
        for (int i = 1; i < WIDTH; i++) begin
            #1;
            check("bubble_advance", add_en, 1);
            step(acc);
        end
        check("bubble_stall", in_ready, 0);
        check("bubble_stall_count", count, DEPTH);
        for (int i = 0; i < 3; i++) step(acc);
        check("bubble_stall_hold", add_en, 0);
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 30 && (exp_q.size() != 0 || out_valid); cyc++) step(acc);
        check("bubble_drain_empty", exp_q.size(), 0);

        // Reset with 3 ops in flight and 2 buffered
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_rand();
            step(acc);
        end
        in_valid = 1'b0;
        step(acc);
        check("mid_buffered", count, 2);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_count", count, 0);
        exp_q.delete();
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 4'h2; in_b = 4'h2; in_cin = 1'b0;
        step(acc);
        check("post_rst_accept", acc, 1);
        in_valid = 1'b0;
        for (int i = 1; i < WIDTH; i++) begin
            step(acc);
            check("post_rst_no_stale", out_valid, 0);
        end
        step(acc);
        check("post_rst_valid", out_valid, 1);
        check("post_rst_s", out_s, 4'h4);
        check("post_rst_c", out_c, 0);
        step(acc);
        for (int i = 0; i < 3; i++) begin
            check("post_rst_empty", out_valid, 0);
            step(acc);
        end
        check("post_rst_count", count, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
